pipelined_adder: RTL

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/pipelined_adder_if.sv | 28 ++
 rtl/pipelined_adder.sv | 119 +++++++++++
 2 files changed

// File: rtl/pipelined_adder_if.sv
// Operand/result bus for pipelined_adder: valid/ready on both sides.
// The adder uses the slave view; whoever feeds it and drains results uses master.
// No state lives here.
interface pipelined_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             ovf;

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, c, ovf
    );

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, c, ovf
    );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined adder/subtractor: one WIDTH/STAGES-bit slice per stage, carry rippled through registers.
// Latency STAGES edges including the accepting edge; one beat per cycle.
// Whole pipe stalls as a unit when the output is valid and not taken (in_ready = !out_valid || out_ready).
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int SAT    = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    pipelined_adder_if.slave  bus
);
    localparam int SL   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Per-stage state: valid, carry out of this stage's slice, partial sum
    // (slices 0..k filled), operands carried forward, and the mode bit.
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] c_q,   c_d;
    logic [STAGES-1:0] sub_q, sub_d;
    logic [WIDTH-1:0]  a_q  [STAGES];
    logic [WIDTH-1:0]  a_d  [STAGES];
    logic [WIDTH-1:0]  bx_q [STAGES];
    logic [WIDTH-1:0]  bx_d [STAGES];
    logic [WIDTH-1:0]  s_q  [STAGES];
    logic [WIDTH-1:0]  s_d  [STAGES];

    logic advance;
    logic carry_into_msb;
    logic [WIDTH-1:0] sat_s;

    assign advance      = !vld_q[LAST] || bus.out_ready;
    assign bus.in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_bx;
        logic [WIDTH-1:0] src_s;
        logic             src_c;
        logic             src_vld;
        logic             src_sub;
        logic [SL:0]      slice;

        if (k == 0) begin : g_first
            // Subtraction is A + ~B + 1; B is inverted once here and carried inverted.
            assign src_vld = bus.in_valid;
            assign src_a   = bus.a;
            assign src_bx  = bus.sub ? ~bus.b : bus.b;
            assign src_c   = bus.sub | bus.cin;
            assign src_sub = bus.sub;
            assign src_s   = '0;
        end else begin : g_next
            assign src_vld = vld_q[k-1];
            assign src_a   = a_q[k-1];
            assign src_bx  = bx_q[k-1];
            assign src_c   = c_q[k-1];
            assign src_sub = sub_q[k-1];
            assign src_s   = s_q[k-1];
        end

        assign slice = {1'b0, src_a[k*SL +: SL]} + {1'b0, src_bx[k*SL +: SL]}
                     + {{SL{1'b0}}, src_c};

        // Merge this stage's slice into the partial sum handed down the pipe.
        always_comb begin
            s_d[k]              = src_s;
            s_d[k][k*SL +: SL]  = slice[SL-1:0];
        end

        assign c_d[k]   = slice[SL];
        assign vld_d[k] = src_vld;
        assign sub_d[k] = src_sub;
        assign a_d[k]   = src_a;
        assign bx_d[k]  = src_bx;
    end

    // Stage registers: async clear, load only when the whole pipe advances.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
            c_q   <= '0;
            sub_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]  <= '0;
                bx_q[k] <= '0;
                s_q[k]  <= '0;
            end
        end else if (advance) begin
            vld_q <= vld_d;
            c_q   <= c_d;
            sub_q <= sub_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]  <= a_d[k];
                bx_q[k] <= bx_d[k];
                s_q[k]  <= s_d[k];
            end
        end
    end

    // Carry into the MSB recovered from the MSB's own sum bit and operands.
    assign carry_into_msb = a_q[LAST][WIDTH-1] ^ bx_q[LAST][WIDTH-1] ^ s_q[LAST][WIDTH-1];

    // Unsigned saturation on the way out; C and OVF stay unsaturated.
    always_comb begin
        sat_s = s_q[LAST];
        if (SAT != 0) begin
            if (!sub_q[LAST] && c_q[LAST]) begin
                sat_s = '1;
            end else if (sub_q[LAST] && !c_q[LAST]) begin
                sat_s = '0;
            end
        end
    end

    assign bus.out_valid = vld_q[LAST];
    assign bus.s         = sat_s;
    assign bus.c         = c_q[LAST];
    assign bus.ovf       = carry_into_msb ^ c_q[LAST];
endmodule
